// File: rtl/counter_bank_arbiter_if.sv
// Request/grant and counter-readout bundle between event sources and the counter bank.
// master drives requests, clears and enable; slave (the bank) returns grants and counter state.
interface counter_bank_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int IDXW = $clog2(NCH);

  logic                  en;
  logic [NCH-1:0]        req;
  logic [NCH-1:0]        clr;
  logic [NCH-1:0]        ack;
  logic                  grant_valid;
  logic [IDXW-1:0]       grant_idx;
  logic [NCH*WIDTH-1:0]  count;
  logic                  cout;
  logic [IDXW-1:0]       cout_idx;

  modport master (
    output en, req, clr,
    input  ack, grant_valid, grant_idx, count, cout, cout_idx
  );

  modport slave (
    input  en, req, clr,
    output ack, grant_valid, grant_idx, count, cout, cout_idx
  );
endinterface

// File: rtl/counter_bank_arbiter.sv
// Bank of NCH counters sharing one incrementer; a round-robin arbiter picks
// which requesting channel uses the adder each cycle, wraps are reported on cout.
module counter_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  counter_bank_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NCH);

  typedef logic [WIDTH-1:0] cnt_t;

  // Shared incrementer: returns {carry, sum} so a wrap from all-ones is visible.
  function automatic logic [WIDTH:0] incr_wrap(input cnt_t v);
    return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  cnt_t            cnt [NCH];
  logic [IDXW-1:0] ptr;
  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  ack;
  logic            gvld;
  logic [IDXW-1:0] gidx;
  logic [IDXW-1:0] cand;
  cnt_t            add_a;
  logic [WIDTH:0]  add_y;
  logic            cout_q;
  logic [IDXW-1:0] cout_idx_q;

  // stage p0: eligibility and circular search starting at ptr
  // Reset is folded in so no grant is shown while the bank is held in reset.
  assign elig = bus.req & ~bus.clr & {NCH{bus.en & ASYNCRESETN}};

  always_comb begin
    ack  = '0;
    gvld = 1'b0;
    gidx = '0;
    cand = '0;
    for (int k = 0; k < NCH; k++) begin
      // NCH is a power of two, so the index add wraps modulo NCH for free.
      cand = ptr + IDXW'(k);
      if (!gvld && elig[cand]) begin
        gvld      = 1'b1;
        gidx      = cand;
        ack[cand] = 1'b1;
      end
    end
  end

  // One adder for the whole bank, fed from the granted channel only.
  assign add_a = cnt[gidx];
  assign add_y = incr_wrap(add_a);

  // stage p1: counter write-back, pointer advance, carry-out register
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ptr        <= '0;
      cout_q     <= 1'b0;
      cout_idx_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.clr[i])  cnt[i] <= '0;
        else if (ack[i]) cnt[i] <= add_y[WIDTH-1:0];
      end
      if (gvld) ptr <= gidx + IDXW'(1);
      cout_q <= gvld & add_y[WIDTH];
      if (gvld && add_y[WIDTH]) cout_idx_q <= gidx;
    end
  end

  assign bus.ack         = ack;
  assign bus.grant_valid = gvld;
  assign bus.grant_idx   = gidx;
  assign bus.cout        = cout_q;
  assign bus.cout_idx    = cout_idx_q;

  for (genvar i = 0; i < NCH; i++) begin : g_flat
    assign bus.count[i*WIDTH +: WIDTH] = cnt[i];
  end
endmodule

// File: doc/counter_bank_arbiter.md
Name: counter_bank_arbiter

Overview:
- Bank of NCH independent WIDTH-bit counters that share one incrementer (adder with carry-out). Only one counter can be incremented per cycle.
- Requesters ask for increments with a req/ack handshake. A round-robin arbiter decides which channel gets the adder each cycle.
- Sits between event sources (pulse counters, timers) and the shared counter datapath. Per-channel wrap events are reported as a carry-out pulse.

Parameters:
- WIDTH, 4, bit width of each counter and of the shared adder.
- NCH, 4, number of channels/requesters (power of two, 2..16).
- IDXW, log2(NCH), width of channel index fields (derived; never overridden).

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; when low, no grants are issued.
- req  input  NCH  per-channel increment request, level; bit i belongs to channel i.
- clr  input  NCH  per-channel synchronous clear to 0.
- ack  output  NCH  one-hot grant, combinational, same cycle as req.
- grant_valid  output  1  OR of ack.
- grant_idx  output  IDXW  index of the granted channel; 0 when grant_valid is low.
- count  output  NCH*WIDTH  flattened counter values; channel i is in bits [i*WIDTH +: WIDTH].
- cout  output  1  registered pulse: a channel wrapped from all-ones to 0.
- cout_idx  output  IDXW  registered index of the wrapping channel; holds its value when cout is low.

Behaviour:
- Reset (ASYNCRESETN low, takes effect immediately):
  - All counts = 0, round-robin pointer ptr = 0.
  - cout = 0, cout_idx = 0.
  - ack = 0 and grant_valid = 0 while reset is held.
  - Release is sampled on the next rising CLK edge.
- Eligibility: channel i is eligible when req[i]=1 and clr[i]=0 and en=1.
- Arbitration (combinational):
  - Grant the first eligible channel found searching circularly from ptr upward: ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1.
  - At most one ack bit is high. No eligible channel gives ack = 0.
- Transfer: a transfer to channel g occurs at the rising edge where ack[g]=1.
  - At that edge, count[g] <= count[g] + 1 through the shared adder, modulo 2^WIDTH.
- Pointer update:
  - On a transfer to g, ptr <= (g+1) mod NCH.
  - With no transfer, ptr holds.
  - Result: a requester holding req is served within NCH cycles (no starvation).
- Back-to-back: a requester may hold req high across cycles. Each cycle in which it sees ack counts as one increment. The requester drops req in the same cycle it sees its final ack.
- Clear:
  - clr[i] sets count[i] <= 0 at the next edge.
  - Any number of channels may clear in the same cycle.
  - clr[i] takes precedence over a request on channel i: that channel is ineligible, gets no ack, and ptr is unaffected by it.
- Clearing and incrementing different channels in the same cycle: both take effect.
- Carry-out:
  - If the transfer edge moves count[g] from 2^WIDTH-1 to 0, then cout=1 and cout_idx=g in the following cycle, for exactly one cycle.
  - A non-wrapping transfer or an idle cycle sets cout=0; cout_idx holds.
- en low: no acks, ptr holds. clr still acts.
- Reset mid-operation: a pending req is dropped with no increment; after release, arbitration restarts at ptr=0.
- Area target: a single WIDTH-bit adder. The adder input is muxed from count[grant_idx]; there are no per-channel adders.

Test Plan:
- Reset release, req=0001 held for 3 cycles -> ack=0001 on each cycle, count[0] = 1, 2, 3, cout stays 0.
- req=1111 held for 5 cycles from reset -> grant_idx sequence 0,1,2,3,0, and each of count[1..3] = 1.
- ptr=2 (after a grant to channel 1), req=0011 -> grant_idx=0 (circular wrap of the search), then ptr=1.
- Channel 2 at 15 (WIDTH=4), req[2] one transfer -> count[2]=0, and the next cycle has cout=1, cout_idx=2, then cout=0.
- req=0110 with clr=0010 in the same cycle -> ack=0100, count[1]=0, count[2] increments.
- Counts nonzero with req active; ASYNCRESETN pulsed low mid-cycle -> counts=0 and ack=0 immediately; after release, req=1000 gives ack=1000, and req=1111 then starts its grant sequence at 0.
